// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI-lite read-channel arbiter.
// Optional watchdog is enabled with AXI_RD_TIMEOUT_EN.
package axi_rd_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        FLUSH
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/axi_rd_arbiter_rr_select.sv
// Combinational round-robin picker: first request after last grant.
// Shared by the read arbiter and any future write-channel arbiter.
module rr_select #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Walk requesters from last+1 with wrap-around, keep the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        sum = '0;
        pos = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            pos = sum[IW-1:0];
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read channel between N requesters.
// Define AXI_RD_TIMEOUT_EN to add the watchdog with SLVERR and stale-beat flush.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [32*N_MASTERS-1:0] core_axi_araddr,
    input  logic [N_MASTERS-1:0]    core_axi_arvalid,
    output logic [N_MASTERS-1:0]    core_axi_arready,
    output logic [31:0]             core_axi_rdata,
    output logic [1:0]              core_axi_rresp,
    output logic [N_MASTERS-1:0]    core_axi_rvalid,
    input  logic [N_MASTERS-1:0]    core_axi_rready,
    output logic [31:0]             mem_axi_araddr,
    output logic                    mem_axi_arvalid,
    input  logic                    mem_axi_arready,
    input  logic [31:0]             mem_axi_rdata,
    input  logic [1:0]              mem_axi_rresp,
    input  logic                    mem_axi_rvalid,
    output logic                    mem_axi_rready
);

    localparam int N  = N_MASTERS;
    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    state_t        state, state_n;
    logic [IW-1:0] last_grant, last_n;
    logic [IW-1:0] gidx, gidx_n;
    logic [N-1:0]  arready_n, rvalid_n;
    logic [31:0]   araddr_n, rdata_n;
    logic [1:0]    rresp_n;
    logic          arvalid_n, rready_n;

    logic [N-1:0]  gnt;
    logic [IW-1:0] sel;
    logic          req_any;
    logic [31:0]   addr_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_addr
        assign addr_arr[i] = core_axi_araddr[32*i +: 32];
    end

    rr_select #(.N(N), .IW(IW)) u_rr (
        .req  (core_axi_arvalid),
        .last (last_grant),
        .gnt  (gnt),
        .idx  (sel),
        .any  (req_any)
    );

`ifdef AXI_RD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          flush, flush_n;
    logic          timeout;
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n   = state;
        last_n    = last_grant;
        gidx_n    = gidx;
        arready_n = '0;
        araddr_n  = mem_axi_araddr;
        arvalid_n = mem_axi_arvalid;
        rready_n  = mem_axi_rready;
        rdata_n   = core_axi_rdata;
        rresp_n   = core_axi_rresp;
        rvalid_n  = core_axi_rvalid;
`ifdef AXI_RD_TIMEOUT_EN
        cnt_n     = cnt;
        flush_n   = flush;
`endif
        case (state)
            IDLE: begin
                if (req_any) begin
                    arready_n = gnt;
                    araddr_n  = addr_arr[sel];
                    arvalid_n = 1'b1;
                    gidx_n    = sel;
                    state_n   = ADDR;
`ifdef AXI_RD_TIMEOUT_EN
                    cnt_n     = '0;
                    flush_n   = 1'b0;
`endif
                end
            end
            ADDR: begin
`ifdef AXI_RD_TIMEOUT_EN
                cnt_n = cnt + CW'(1);
`endif
                if (mem_axi_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = DATA;
                end
`ifdef AXI_RD_TIMEOUT_EN
                else if (timeout) begin
                    arvalid_n = 1'b0;
                    rdata_n   = '0;
                    rresp_n   = RESP_SLVERR;
                    rvalid_n  = ONE << gidx;
                    state_n   = RESP;
                end
`endif
            end
            DATA: begin
`ifdef AXI_RD_TIMEOUT_EN
                cnt_n = cnt + CW'(1);
`endif
                if (mem_axi_rvalid) begin
                    rdata_n  = mem_axi_rdata;
                    rresp_n  = mem_axi_rresp;
                    rready_n = 1'b0;
                    rvalid_n = ONE << gidx;
                    state_n  = RESP;
                end
`ifdef AXI_RD_TIMEOUT_EN
                else if (timeout) begin
                    rready_n = 1'b0;
                    rdata_n  = '0;
                    rresp_n  = RESP_SLVERR;
                    rvalid_n = ONE << gidx;
                    flush_n  = 1'b1;
                    state_n  = RESP;
                end
`endif
            end
            RESP: begin
                if (core_axi_rready[gidx]) begin
                    rvalid_n = '0;
                    last_n   = gidx;
                    state_n  = IDLE;
`ifdef AXI_RD_TIMEOUT_EN
                    if (flush) begin
                        rready_n = 1'b1;
                        state_n  = FLUSH;
                    end
`endif
                end
            end
`ifdef AXI_RD_TIMEOUT_EN
            FLUSH: begin
                if (mem_axi_rvalid) begin
                    rready_n = 1'b0;
                    state_n  = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            last_grant       <= IW'(N - 1);
            gidx             <= '0;
            core_axi_arready <= '0;
            core_axi_rdata   <= '0;
            core_axi_rresp   <= '0;
            core_axi_rvalid  <= '0;
            mem_axi_araddr   <= '0;
            mem_axi_arvalid  <= 1'b0;
            mem_axi_rready   <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
            cnt              <= '0;
            flush            <= 1'b0;
`endif
        end else begin
            state            <= state_n;
            last_grant       <= last_n;
            gidx             <= gidx_n;
            core_axi_arready <= arready_n;
            core_axi_rdata   <= rdata_n;
            core_axi_rresp   <= rresp_n;
            core_axi_rvalid  <= rvalid_n;
            mem_axi_araddr   <= araddr_n;
            mem_axi_arvalid  <= arvalid_n;
            mem_axi_rready   <= rready_n;
`ifdef AXI_RD_TIMEOUT_EN
            cnt              <= cnt_n;
            flush            <= flush_n;
`endif
        end
    end

endmodule
